// File: rtl/fast_serial_pkg.sv
// Shared constants, FSM encodings and the byte-plus-channel word
// used by the fast-opto serial engine.
package fast_serial_pkg;

   localparam int   FS_FRAME_BITS = 10;
   localparam logic FS_START      = 1'b0;
   localparam logic FS_IDLE       = 1'b1;
   localparam logic FS_CHAN_A     = 1'b0;
   localparam logic FS_CHAN_B     = 1'b1;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_DATA,
      TX_GAP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_SHIFT,
      RX_PUSH
   } rx_state_t;

   typedef struct packed {
      logic       chan;
      logic [7:0] data;
   } fs_word_t;

endpackage

// File: rtl/fs_sync_fifo.sv
// Single-clock FIFO with occupancy output; read data is the head entry,
// a pushed entry becomes visible on the following cycle.
module fs_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp;
   logic [AW-1:0]    rp;
   logic             wr;
   logic             rd;

   assign o_empty = (o_level == '0);
   assign o_full  = (o_level == LW'(DEPTH));
   assign rd      = i_pop & ~o_empty;
   // a pop frees the slot this cycle, so a full FIFO may still accept
   assign wr      = i_push & (~o_full | rd);
   assign o_rdata = mem[rp];

   always_ff @(posedge i_clk) begin
      if (wr) mem[wp] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wp      <= '0;
         rp      <= '0;
         o_level <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
         if (wr && !rd)
            o_level <= o_level + 1'b1;
         else if (rd && !wr)
            o_level <= o_level - 1'b1;
      end
   end

endmodule

// File: rtl/fast_serial_core.sv
// FTDI fast-opto serial engine: FSCLK divider, TX and RX framers
// with byte FIFOs on the system side.
module fast_serial_core
   import fast_serial_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int TX_DEPTH  = 16,
   parameter int RX_DEPTH  = 16,
   parameter int IDLE_BITS = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [7:0]                  i_tx_data,
   input  logic                        i_tx_chan,
   input  logic                        i_tx_valid,
   output logic                        o_tx_ready,
   output logic [7:0]                  o_rx_data,
   output logic                        o_rx_chan,
   output logic                        o_rx_valid,
   input  logic                        i_rx_ready,
   output logic                        o_fsclk,
   output logic                        o_fsdi,
   input  logic                        i_fsdo,
   input  logic                        i_fscts,
   output logic [$clog2(TX_DEPTH):0]   o_tx_level,
   output logic [$clog2(RX_DEPTH):0]   o_rx_level,
   output logic                        o_rx_overflow,
   input  logic                        i_clr_overflow,
   output logic                        o_tx_active
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int GW = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;

   logic          rst_meta;
   logic          rst_s;
   logic [DW-1:0] div_cnt;
   logic          div_wrap;
   logic          rise_tick;
   logic          fall_tick;
   logic          cts_m;
   logic          cts_s;
   logic          fsdo_q;

   tx_state_t     tx_state_q, tx_state_d;
   logic [3:0]    tx_cnt_q, tx_cnt_d;
   logic [8:0]    tx_sh_q, tx_sh_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          fsdi_d;
   logic          act_d;
   logic          tx_pop;
   logic          tx_push;
   logic          tx_full;
   logic          tx_empty;
   fs_word_t      tx_head;

   rx_state_t     rx_state_q, rx_state_d;
   logic [3:0]    rx_cnt_q, rx_cnt_d;
   logic [8:0]    rx_sh_q, rx_sh_d;
   logic          rx_req;
   logic          rx_push;
   logic          rx_drop;
   logic          rx_pop;
   logic          rx_full;
   logic          rx_empty;
   fs_word_t      rx_head;

   // async assert, release aligned to i_clk
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rst_meta <= 1'b0;
         rst_s    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_s    <= rst_meta;
      end
   end

   assign div_wrap  = (div_cnt == DW'(CLK_DIV - 1));
   assign rise_tick = div_wrap & ~o_fsclk;
   assign fall_tick = div_wrap & o_fsclk;

   always_ff @(posedge i_clk or negedge rst_s) begin
      if (!rst_s) begin
         div_cnt <= '0;
         o_fsclk <= 1'b0;
         cts_m   <= 1'b0;
         cts_s   <= 1'b0;
         fsdo_q  <= FS_IDLE;
      end else begin
         div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
         if (div_wrap) o_fsclk <= ~o_fsclk;
         cts_m   <= i_fscts;
         cts_s   <= cts_m;
         fsdo_q  <= i_fsdo;
      end
   end

   assign o_tx_ready = ~tx_full;
   assign tx_push    = i_tx_valid & o_tx_ready;

   fs_sync_fifo #(
      .WIDTH (9),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .i_clk   (i_clk),
      .i_rst_n (rst_s),
      .i_push  (tx_push),
      .i_wdata ({i_tx_chan, i_tx_data}),
      .i_pop   (tx_pop),
      .o_rdata (tx_head),
      .o_level (o_tx_level),
      .o_full  (tx_full),
      .o_empty (tx_empty)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_sh_d    = tx_sh_q;
      gap_d      = gap_q;
      fsdi_d     = o_fsdi;
      act_d      = o_tx_active;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         TX_IDLE: begin
            if (fall_tick && !tx_empty && cts_s) begin
               tx_pop     = 1'b1;
               tx_sh_d    = tx_head;
               tx_cnt_d   = '0;
               fsdi_d     = FS_START;
               act_d      = 1'b1;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (fall_tick) begin
               if (tx_cnt_q == 4'(FS_FRAME_BITS - 1)) begin
                  fsdi_d     = FS_IDLE;
                  act_d      = 1'b0;
                  gap_d      = '0;
                  tx_state_d = TX_GAP;
               end else begin
                  fsdi_d   = tx_sh_q[0];
                  tx_sh_d  = {1'b0, tx_sh_q[8:1]};
                  tx_cnt_d = tx_cnt_q + 1'b1;
               end
            end
         end
         TX_GAP: begin
            // the high bit driven on leaving DATA is the first gap period
            if (gap_q == GW'(IDLE_BITS - 1))
               tx_state_d = TX_IDLE;
            else if (fall_tick)
               gap_d = gap_q + 1'b1;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge rst_s) begin
      if (!rst_s) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_sh_q     <= '0;
         gap_q       <= '0;
         o_fsdi      <= FS_IDLE;
         o_tx_active <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_sh_q     <= tx_sh_d;
         gap_q       <= gap_d;
         o_fsdi      <= fsdi_d;
         o_tx_active <= act_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_sh_d    = rx_sh_q;
      rx_req     = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rise_tick && fsdo_q == FS_START) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (rise_tick) begin
               rx_sh_d = {fsdo_q, rx_sh_q[8:1]};
               if (rx_cnt_q == 4'(FS_FRAME_BITS - 2))
                  rx_state_d = RX_PUSH;
               else
                  rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_PUSH: begin
            rx_req     = 1'b1;
            rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge rst_s) begin
      if (!rst_s) begin
         rx_state_q    <= RX_IDLE;
         rx_cnt_q      <= '0;
         rx_sh_q       <= '0;
         o_rx_overflow <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_sh_q    <= rx_sh_d;
         if (rx_drop)
            o_rx_overflow <= 1'b1;
         else if (i_clr_overflow)
            o_rx_overflow <= 1'b0;
      end
   end

   assign rx_push    = rx_req & ~rx_full;
   assign rx_drop    = rx_req & rx_full;
   assign rx_pop     = i_rx_ready & ~rx_empty;
   assign o_rx_valid = ~rx_empty;
   assign o_rx_data  = rx_head.data;
   assign o_rx_chan  = rx_head.chan;

   fs_sync_fifo #(
      .WIDTH (9),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .i_clk   (i_clk),
      .i_rst_n (rst_s),
      .i_push  (rx_push),
      .i_wdata (rx_sh_q),
      .i_pop   (rx_pop),
      .o_rdata (rx_head),
      .o_level (o_rx_level),
      .o_full  (rx_full),
      .o_empty (rx_empty)
   );

endmodule
